// File: rtl/crc_pkg.sv
// Shared CRC-4 definitions used by the generator and checker sides of the link.
package crc_pkg;

   localparam int               CRC_W            = 4;
   localparam logic [CRC_W-1:0] CRC_POLY_DEFAULT = 4'b0011;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } crc_state_e;

endpackage

// File: rtl/crc4_step.sv
// One serial CRC-4 step: shift in a single bit, MSB-first, against the given polynomial.
module crc4_step
   import crc_pkg::*;
(
   input  logic [CRC_W-1:0] i_r,
   input  logic             i_bit,
   input  logic [CRC_W-1:0] i_poly,
   output logic [CRC_W-1:0] o_r_next
);

   logic w_fb;

   assign w_fb     = i_r[CRC_W-1] ^ i_bit;
   assign o_r_next = {i_r[CRC_W-2:0], 1'b0} ^ (w_fb ? i_poly : '0);

endmodule

// File: rtl/crc4_checker.sv
// Receive-side CRC-4 checker: bit-serial recompute over a framed byte stream,
// then runs the transmitted CRC through the same register and reports pass/fail and length.
module crc4_checker
   import crc_pkg::*;
#(
   parameter logic [CRC_W-1:0] POLY  = CRC_POLY_DEFAULT,
   parameter int               LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   // in_valid/in_ready: a byte moves on a rising edge where both are high;
   // the source holds in_data/in_last/in_crc stable until that edge.
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   input  logic [CRC_W-1:0] in_crc,
   output logic             out_valid,
   output logic             out_ok,
   output logic [CRC_W-1:0] out_crc_calc,
   output logic [LEN_W-1:0] out_len,
   output logic [1:0]       out_dbg_state
);

   crc_state_e       r_state;
   crc_state_e       w_next;
   logic [CRC_W-1:0] r_crc;
   logic [CRC_W-1:0] w_crc_step;
   logic [7:0]       r_shift;
   logic [2:0]       r_bit_cnt;
   logic [LEN_W-1:0] r_cnt;
   logic [CRC_W-1:0] r_crc_in;
   logic             r_last;
   logic             r_ok;
   logic [CRC_W-1:0] r_crc_calc;
   logic [LEN_W-1:0] r_len;
   logic             w_accept;
   logic             w_bit;

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = !rst;
            if (in_valid && !rst) w_next = SHIFT;
         end
         SHIFT: begin
            if (r_bit_cnt == 3'd0) w_next = r_last ? CHECK : IDLE;
         end
         CHECK: begin
            if (r_bit_cnt == 3'd0) w_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            w_next    = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   assign w_accept = in_valid && in_ready;
   // In CHECK the same step consumes the received CRC, so a clean frame leaves r at zero.
   assign w_bit    = (r_state == CHECK) ? r_crc_in[r_bit_cnt[1:0]] : r_shift[7];

   crc4_step u_step (
      .i_r      (r_crc),
      .i_bit    (w_bit),
      .i_poly   (POLY),
      .o_r_next (w_crc_step)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_crc      <= '0;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_cnt      <= '0;
         r_crc_in   <= '0;
         r_last     <= 1'b0;
         r_ok       <= 1'b0;
         r_crc_calc <= '0;
         r_len      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_shift   <= in_data;
                  r_last    <= in_last;
                  r_bit_cnt <= 3'd7;
                  if (in_last) r_crc_in <= in_crc;
                  if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
               end
            end
            SHIFT: begin
               r_crc     <= w_crc_step;
               r_shift   <= {r_shift[6:0], 1'b0};
               r_bit_cnt <= r_bit_cnt - 1'b1;
               if (r_bit_cnt == 3'd0 && r_last) r_bit_cnt <= 3'd3;
            end
            CHECK: begin
               if (r_bit_cnt == 3'd3) r_crc_calc <= r_crc;
               r_crc     <= w_crc_step;
               r_bit_cnt <= r_bit_cnt - 1'b1;
               // Result registers load on the final check step so they are live during DONE.
               if (r_bit_cnt == 3'd0) begin
                  r_ok  <= (w_crc_step == '0);
                  r_len <= r_cnt;
               end
            end
            DONE: begin
               r_crc <= '0;
               r_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   assign out_ok        = r_ok;
   assign out_crc_calc  = r_crc_calc;
   assign out_len       = r_len;
   assign out_dbg_state = r_state;

endmodule

// File: tb/tb_crc4_checker.sv
// Bench for crc4_checker: directed frames plus random frames against a polynomial-division model.
module tb_crc4_checker;
   import crc_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready, in_ready2;
   logic [7:0] in_data;
   logic       in_last;
   logic [3:0] in_crc;
   logic       out_valid, out_valid2;
   logic       out_ok, out_ok2;
   logic [3:0] out_crc_calc, out_crc_calc2;
   logic [7:0] out_len;
   logic [1:0] out_len2;
   logic [1:0] dbg, dbg2;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int n_outv = 0;
   int n_hs   = 0;

   logic [7:0]  fb[8];
   logic [12:0] exp_q[$];

   crc4_checker #(.LEN_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .in_crc(in_crc),
      .out_valid(out_valid), .out_ok(out_ok), .out_crc_calc(out_crc_calc),
      .out_len(out_len), .out_dbg_state(dbg)
   );

   crc4_checker #(.LEN_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .in_data(in_data), .in_last(in_last), .in_crc(in_crc),
      .out_valid(out_valid2), .out_ok(out_ok2), .out_crc_calc(out_crc_calc2),
      .out_len(out_len2), .out_dbg_state(dbg2)
   );

   // clock / cycle bookkeeping
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (out_valid) n_outv <= n_outv + 1;
      if (in_valid && in_ready) n_hs <= n_hs + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // reference: remainder of M(x)*x^4 divided by x^4+x+1 by long division
   function automatic logic [3:0] ref_crc(input int n);
      logic [63:0] m;
      logic [63:0] g;
      m = '0;
      g = 64'h13;
      for (int i = 0; i < n; i++) m = (m << 8) | {56'd0, fb[i]};
      m = m << 4;
      for (int i = 8 * n + 3; i >= 4; i--)
         if (m[i]) m = m ^ (g << (i - 4));
      return m[3:0];
   endfunction

   // driver: present one byte at a negedge, return the cycle of its handshake
   task automatic send_byte(input logic [7:0] d, input logic l, input logic [3:0] c,
                            input bit hold_after, output int t);
      int w;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      in_crc   = c;
      w = 0;
      while (!in_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      t = cyc;
      @(negedge clk);
      if (!hold_after) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         in_last  = 1'($urandom);
         in_crc   = 4'($urandom);
      end
   endtask

   task automatic run_frame(input int n, input logic [3:0] crc, input bit hold);
      int          t[8];
      int          w;
      int          outv0, hs0;
      logic [3:0]  e_crc;
      logic [12:0] e;
      e_crc = ref_crc(n);
      exp_q.push_back({(e_crc == crc), e_crc, 8'(n)});
      outv0 = n_outv;
      hs0   = n_hs;
      for (int i = 0; i < n; i++) begin
         send_byte(fb[i], (i == n - 1), (i == n - 1) ? crc : 4'($urandom),
                   hold && (i < n - 1), t[i]);
         if (!hold && i < n - 1) repeat ($urandom_range(0, 10)) @(negedge clk);
      end
      if (hold)
         for (int i = 1; i < n; i++) chk("hs_spacing", 32'(t[i] - t[i-1]), 32'd9);
      w = 0;
      while (!out_valid && w < 30) begin
         @(negedge clk);
         w++;
      end
      chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
      chk("latency", 32'(cyc - t[n-1]), 32'd13);
      chk("ready_in_done", {31'd0, in_ready}, 32'd0);
      e = exp_q.pop_front();
      chk("out_ok", {31'd0, out_ok}, {31'd0, e[12]});
      chk("out_crc_calc", {28'd0, out_crc_calc}, {28'd0, e[11:8]});
      chk("out_len", {24'd0, out_len}, {24'd0, e[7:0]});
      chk("sat_valid", {31'd0, out_valid2}, 32'd1);
      chk("sat_ok", {31'd0, out_ok2}, {31'd0, e[12]});
      chk("sat_len", {30'd0, out_len2}, (n > 3) ? 32'd3 : 32'(n));
      @(negedge clk);
      chk("valid_one_cycle", {31'd0, out_valid}, 32'd0);
      chk("ready_after_done", {31'd0, in_ready}, 32'd1);
      chk("result_hold", {28'd0, out_crc_calc}, {28'd0, e[11:8]});
      chk("strobe_count", 32'(n_outv - outv0), 32'd1);
      chk("handshake_count", 32'(n_hs - hs0), 32'(n));
   endtask

   initial begin
      int t;
      int outv0;
      int n;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      in_crc   = '0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_ok", {31'd0, out_ok}, 32'd0);
      chk("rst_crc", {28'd0, out_crc_calc}, 32'd0);
      chk("rst_len", {24'd0, out_len}, 32'd0);
      chk("rst_state", {30'd0, dbg}, {30'd0, IDLE});
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

      // single byte, matching and mismatching CRC
      fb[0] = 8'h01;
      run_frame(1, 4'h3, 1'b0);
      run_frame(1, 4'h2, 1'b0);

      // two-byte frame then an immediate second frame
      fb[0] = 8'h01; fb[1] = 8'h00;
      run_frame(2, 4'hF, 1'b0);
      fb[0] = 8'h10;
      run_frame(1, 4'h5, 1'b0);

      // in_valid held high across a 3-byte frame
      for (int i = 0; i < 3; i++) fb[i] = 8'($urandom);
      run_frame(3, ref_crc(3), 1'b1);

      // reset during SHIFT of the second byte
      outv0 = n_outv;
      send_byte(8'h01, 1'b0, 4'h0, 1'b0, t);
      send_byte(8'h22, 1'b0, 4'h0, 1'b0, t);
      #2 rst = 1'b1;
      #1;
      chk("midrst_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("midrst_ready_hold", {31'd0, in_ready}, 32'd0);
      chk("midrst_crc", {28'd0, out_crc_calc}, 32'd0);
      chk("midrst_len", {24'd0, out_len}, 32'd0);
      chk("midrst_ok", {31'd0, out_ok}, 32'd0);
      chk("midrst_state", {30'd0, dbg}, {30'd0, IDLE});
      #2 rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("midrst_no_strobe", 32'(n_outv - outv0), 32'd0);
      fb[0] = 8'h01;
      run_frame(1, 4'h3, 1'b0);

      // saturation on the narrow counter
      for (int i = 0; i < 5; i++) fb[i] = 8'h00;
      run_frame(5, 4'h0, 1'b0);

      // random frames
      for (int k = 0; k < 20; k++) begin
         n = $urandom_range(1, 7);
         for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
         repeat ($urandom_range(0, 4)) @(negedge clk);
         run_frame(n, ($urandom_range(0, 1) == 1) ? ref_crc(n) : 4'($urandom),
                   ($urandom_range(0, 3) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/crc4_checker.md
Name: crc4_checker

Overview:
Receive-side counterpart of the team's CRC-4 generator. It accepts a framed byte stream over a valid/ready handshake and recomputes the CRC-4 serially, one bit per clock, MSB first. It then compares the result against the transmitted 4-bit CRC delivered with the last byte and reports pass/fail plus the frame length. It sits on the link receive path ahead of the frame consumer.

Parameters:
POLY, 4'b0011, generator low-order coefficients (x^4 implicit; default x^4+x+1)
LEN_W, 8, width of frame byte counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  byte available
in_ready  out  1  checker can accept a byte
in_data  in  8  data byte, MSB processed first
in_last  in  1  qualifies final byte of frame
in_crc  in  4  transmitted CRC; sampled only on last-byte handshake
out_valid  out  1  one-cycle result strobe
out_ok  out  1  1 = CRC match; valid with out_valid
out_crc_calc  out  4  CRC computed over data bytes; valid with out_valid
out_len  out  LEN_W  bytes in frame, saturating; valid with out_valid

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- CRC definition:
  - init 0, no reflection, no final XOR.
  - Per bit b: fb = r[3]^b; r = {r[2:0],1'b0} ^ (fb ? POLY : 0).
  - Equivalent to the remainder of M(x)*x^4 mod G(x).
- Reset (async assert): state=IDLE; r, shift reg, bit count, byte count, stored crc/last all cleared.
  - out_valid=0, out_ok=0, out_crc_calc=0, out_len=0.
  - in_ready=0 while rst is high.
- FSM states: IDLE, SHIFT, CHECK, DONE.
- IDLE:
  - in_ready=1 (combinational from state, gated by !rst).
  - On in_valid&&in_ready: load in_data into the shift reg, latch in_last; if in_last, latch in_crc.
  - Byte count increments, saturating at 2^LEN_W-1. Go to SHIFT with bit_cnt=7.
- SHIFT:
  - in_ready=0. Each cycle, process the shift-reg MSB into r, shift left, decrement bit_cnt.
  - After bit_cnt=0 is processed: go to CHECK if the latched last=1, else IDLE (r retained, frame continues).
- CHECK:
  - Entry cycle: snapshot r into out_crc_calc register.
  - Over 4 cycles, feed the stored in_crc bits MSB first through the same step. Then go to DONE.
- DONE:
  - out_valid=1 for exactly one cycle.
  - out_ok=(r==0), which equals (out_crc_calc==in_crc); out_len=byte count.
  - Clear r and byte count; next state IDLE.
  - out_crc_calc/out_ok/out_len hold until the next DONE.
- Latency:
  - Handshake at cycle T; SHIFT covers T+1..T+8.
  - Non-last byte: in_ready re-asserts at T+9.
  - Last byte: CHECK at T+9..T+12, out_valid at T+13, in_ready at T+14.
- Throughput: 9 cycles per byte. There is no output backpressure; the consumer must take the strobe.
- Boundaries:
  - in_valid held while busy: no acceptance; the source must hold data.
  - in_crc and in_last are ignored on non-handshake cycles.
  - Back-to-back frames: r and count restart at 0 for each new frame.
  - Single-byte frames are legal; a zero-byte frame is impossible.
  - Count saturates and does not wrap.
  - rst mid-frame aborts the frame silently: no out_valid, and the partial CRC is discarded.

Decomposition:
- Shared package crc_pkg:
  - CRC_W=4 and default POLY constant (shared with the generator);
  - state enum {IDLE, SHIFT, CHECK, DONE}.
- One combinational sub-module, crc4_step (r, bit, poly -> r_next), is natural. It is reused by the generator and lets the verifier unit-test the step.

Test Plan:
- Single byte 0x01, last=1, in_crc=0x3 -> out_valid 13 cycles after handshake; out_ok=1, out_crc_calc=0x3, out_len=1.
- Single byte 0x01, in_crc=0x2 -> out_ok=0, out_crc_calc=0x3, out_len=1.
- Bytes 0x01, 0x00 (last), in_crc=0xF -> out_ok=1, out_crc_calc=0xF, out_len=2. Then frame 0x10, crc 0x5, immediately after -> out_ok=1 (no carry-over).
- in_valid held high continuously across a 3-byte frame -> in_ready high only 1 cycle per 9. Exactly 3 handshakes, correct CRC.
- rst pulsed during SHIFT of byte 2 -> in_ready=0 during reset, no out_valid. Outputs 0. Next frame 0x01/crc 0x3 passes.
- LEN_W=2, 5-byte frame of 0x00, in_crc=0x0 -> out_len=3 (saturated), out_ok=1.
